// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin scheduler sharing one i2c_master among NUM_REQ requesters
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort transfers that exceed TIMEOUT_CYCLES.
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_op,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_ack_err,
    output logic                 rsp_timeout,
    output logic                 m_newd,
    output logic [6:0]           m_addr,
    output logic                 m_op,
    output logic [7:0]           m_din,
    input  logic [7:0]           m_dout,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    output logic                 m_rst
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
    state_t        state;
    logic [PW-1:0] ptr, gnt, gnt_nxt, idx;
    logic          expired;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("i2c_arbiter: unsupported parameters");
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] cnt;
    assign expired = (state == ISSUE || state == WAIT_DONE) && cnt == 32'(TIMEOUT_CYCLES - 1);
    // Cycle count of the active transfer; zero on the first ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (state == ISSUE || state == WAIT_DONE) ? cnt + 32'd1 : '0;
    end
`else
    assign expired = 1'b0;
`endif

    // Round-robin pick: scan from ptr upward, nearest pending requester wins
    always_comb begin
        gnt_nxt = ptr;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) gnt_nxt = idx;
        end
    end

    // Transaction sequencer with registered handshakes and master controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_ack_err <= 1'b0;
            rsp_timeout <= 1'b0;
            m_newd      <= 1'b0;
            m_addr      <= '0;
            m_op        <= 1'b0;
            m_din       <= '0;
            m_rst       <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_rst     <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid && !m_busy) begin
                        req_ready[gnt_nxt] <= 1'b1;
                        gnt    <= gnt_nxt;
                        ptr    <= PW'((int'(gnt_nxt) + 1) % NUM_REQ);
                        m_addr <= req_addr[7*gnt_nxt +: 7];
                        m_op   <= req_op[gnt_nxt];
                        m_din  <= req_wdata[8*gnt_nxt +: 8];
                        m_newd <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    if (expired) begin
                        m_rst          <= 1'b1;
                        m_newd         <= 1'b0;
                        rsp_valid[gnt] <= 1'b1;
                        rsp_timeout    <= 1'b1;
                        rsp_ack_err    <= 1'b1;
                        rsp_rdata      <= '0;
                        state          <= GAP;
                    end else if (state == ISSUE) begin
                        if (m_busy) begin
                            m_newd <= 1'b0;
                            state  <= WAIT_DONE;
                        end
                    end else if (m_done) begin
                        rsp_valid[gnt] <= 1'b1;
                        rsp_ack_err    <= m_ack_err;
                        rsp_timeout    <= 1'b0;
                        rsp_rdata      <= m_op ? m_dout : 8'h00;
                        state          <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
